branch_pred_unit: RTL
=====================

# branch_pred_unit

Parametrised branch prediction unit for the 5-stage RV32I core: a direct-mapped, tagged BTB with typed entries, a bimodal table of saturating counters and a circular return-address stack (RAS). It replaces the fixed-size BTB/Bpred pair. It is looked up in IF with pcF and produces hitF, predF and targetF for pc_gen. It is trained from ID, where branches and jumps resolve, under the hazard unit's stall control.

## Interface
- INDEX_SIZE, 6: BTB and counter table have 2^INDEX_SIZE entries.
- TAG_SIZE, 8: tag bits stored per BTB entry.
- CTR_WIDTH, 2: saturating counter width, minimum 1.
- RAS_DEPTH, 4: return-stack entries, power of two, minimum 2.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- pcF, input, 32: fetch PC.
- hitF, output, 1: BTB tag match on a valid entry.
- predF, output, 1: predict redirect.
- targetF, output, 32: predicted target.
- stallD, input, 1: ID stage held; blocks all updates.
- updD, input, 1: ID holds a resolved control-transfer instruction.
- typeD, input, 2: 00 conditional branch, 01 direct jump (jal), 10 return (jalr rs1=x1, rd=x0), 11 indirect (other jalr).
- takenD, input, 1: resolved direction; ignored for types other than 00.
- pcD, input, 32: PC of the ID instruction.
- targetD, input, 32: resolved target.
- callD, input, 1: ID instruction writes x1 (jal/jalr with rd=x1).
- pcplus4D, input, 32: return address to push.

## Operation
- Index: pc[INDEX_SIZE+1:2]. Tag: pc[INDEX_SIZE+TAG_SIZE+1:INDEX_SIZE+2].
- Per-entry state: valid, tag, type (2 bits), target (32 bits), plus ctr (CTR_WIDTH bits) in a separate untagged table.
- Lookup is combinational from pcF.
  - hitF = valid && (tag match).
  - predF when hitF:
    - type 00: ctr MSB.
    - type 01 or 11: 1.
    - type 10: 1 if RAS count > 0, else 0.
  - predF = 0 when !hitF.
  - targetF: RAS top for a type-10 hit; otherwise the stored target; 0 on a miss.
- Updates take effect only on cycles where updD && !stallD:
  - Counter: type 00 only. takenD=1 increments, saturating at 2^CTR_WIDTH-1. takenD=0 decrements, saturating at 0.
  - BTB write condition: type 00 with takenD=1, or any type ≠ 00.
  - BTB write: set valid, tag, type and target at index(pcD), overwriting any tag. Not-taken branches never allocate but leave an existing entry intact.
  - RAS: retD-type (type 10) pops; callD pushes pcplus4D.
    - Both in one cycle: top is replaced, count unchanged.
    - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
    - Pop when empty is a no-op.
- callD && !stallD pushes even when updD=0 is not possible. callD is only legal together with updD=1 (types 01/11); the bench asserts this.

## Timing
- Reset (reset low, asynchronous):
  - All valid bits and the RAS pointer/count clear.
  - Every counter = 2^(CTR_WIDTH-1)-1 (weakly not-taken).
  - With valid cleared, outputs are hitF=0, predF=0, targetF=0.
  - Target/tag storage need not reset.
- Lookup latency: 0 cycles; outputs settle combinationally from pcF and the registered state.
- Update latency: the state written at rising edge N is visible to a pcF lookup in cycle N+1.
- Same-cycle lookup and update of one index: the lookup returns the pre-update contents. No bypass.
- Reset asserted mid-update: the update is discarded and reset values win.
- Counter and RAS arithmetic are modulo their widths, with explicit saturation as above. The RAS pointer wraps modulo RAS_DEPTH.

## Test plan
- Reset with a weak-not-taken counter:
  - Stimulus: release reset, pcF=0x100.
  - Required: hitF=0, predF=0, targetF=0.
  - Then: one update (type 00, taken, pcD=0x100, targetD=0x180); next cycle pcF=0x100.
  - Required: hitF=1, predF=1 (ctr 01→10), targetF=0x180.
- Counter saturation and hysteresis:
  - Stimulus: 4 taken updates, then 1 not-taken at pcD=0x100.
  - Required: predF=1 (ctr 11→10).
  - Then: 1 more not-taken.
  - Required: predF=0, hitF still 1.
- Stall gating and read-before-write:
  - Stimulus: updD=1 with stallD=1.
  - Required: no state change.
  - Stimulus: update and lookup of the same index in one cycle.
  - Required: the old value is seen that cycle and the new value the next.
- Tag aliasing:
  - Stimulus: with INDEX_SIZE=6, write pcD=0x100 (target 0x180) and then pcD=0x200 (target 0x300), sharing index 0.
  - Required: lookup at 0x100 gives hitF=0; lookup at 0x200 gives hitF=1, targetF=0x300.
- RAS:
  - Stimulus: calls pushing 0x104, 0x204, 0x304 and 0x404, then a 5th call pushing 0x504 (RAS_DEPTH=4).
  - Required: 5 return-type hits yield targets 0x504, 0x404, 0x304, 0x204, then predF=0 (empty).
  - Stimulus: simultaneous pop+push.
  - Required: top replaced, depth unchanged.
- Asynchronous reset mid-run:
  - Stimulus: drop reset between clock edges with valid entries present.
  - Required: hitF=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/branch_pred_unit.sv
// Branch predictor for the 5-stage RV32I core: a tagged direct-mapped BTB, bimodal counters and a circular RAS.
// Lookup is combinational from pcF. Training comes from ID and is gated by stallD.
module branch_pred_unit #(
   parameter int INDEX_SIZE = 6,
   parameter int TAG_SIZE   = 8,
   parameter int CTR_WIDTH  = 2,
   parameter int RAS_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pcF,
   output logic        hitF,
   output logic        predF,
   output logic [31:0] targetF,
   input  logic        stallD,
   input  logic        updD,
   input  logic [1:0]  typeD,
   input  logic        takenD,
   input  logic [31:0] pcD,
   input  logic [31:0] targetD,
   input  logic        callD,
   input  logic [31:0] pcplus4D
);

   localparam int ENTRIES = 1 << INDEX_SIZE;
   localparam int PTR_W   = $clog2(RAS_DEPTH);
   localparam int CNT_W   = $clog2(RAS_DEPTH + 1);
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
   localparam logic [CNT_W-1:0]     RAS_FULL = CNT_W'(RAS_DEPTH);

   localparam logic [1:0] BR_COND = 2'b00;
   localparam logic [1:0] BR_RET  = 2'b10;

   logic [ENTRIES-1:0]   valid_q, valid_d;
   logic [CTR_WIDTH-1:0] ctr_q    [ENTRIES];
   logic [CTR_WIDTH-1:0] ctr_d    [ENTRIES];
   logic [TAG_SIZE-1:0]  tag_q    [ENTRIES];
   logic [TAG_SIZE-1:0]  tag_d    [ENTRIES];
   logic [1:0]           type_q   [ENTRIES];
   logic [1:0]           type_d   [ENTRIES];
   logic [31:0]          target_q [ENTRIES];
   logic [31:0]          target_d [ENTRIES];
   logic [31:0]          ras_q    [RAS_DEPTH];
   logic [31:0]          ras_d    [RAS_DEPTH];
   logic [PTR_W-1:0]     ras_ptr_q, ras_ptr_d;
   logic [CNT_W-1:0]     ras_cnt_q, ras_cnt_d;

   logic [INDEX_SIZE-1:0] look_idx, upd_idx;
   logic [TAG_SIZE-1:0]   look_tag, upd_tag;
   logic                  look_hit;
   logic                  upd_en, btb_wr, ctr_wr, ras_push, ras_pop;
   logic [PTR_W-1:0]      ras_ptr_inc, ras_ptr_dec;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pcF[31:INDEX_SIZE+TAG_SIZE+2], pcF[1:0],
                             pcD[31:INDEX_SIZE+TAG_SIZE+2], pcD[1:0]};

   assign look_idx = pcF[INDEX_SIZE+1:2];
   assign look_tag = pcF[INDEX_SIZE+TAG_SIZE+1:INDEX_SIZE+2];
   assign upd_idx  = pcD[INDEX_SIZE+1:2];
   assign upd_tag  = pcD[INDEX_SIZE+TAG_SIZE+1:INDEX_SIZE+2];

   always_comb begin
      look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
      predF    = 1'b0;
      targetF  = 32'h0;
      if (look_hit) begin
         case (type_q[look_idx])
            BR_COND: begin
               predF   = ctr_q[look_idx][CTR_WIDTH-1];
               targetF = target_q[look_idx];
            end
            BR_RET: begin
               predF   = (ras_cnt_q != '0);
               targetF = ras_q[ras_ptr_q];
            end
            default: begin
               predF   = 1'b1;
               targetF = target_q[look_idx];
            end
         endcase
      end
      hitF = look_hit;
   end

   // Not-taken branches train the counter but never allocate a BTB entry.
   always_comb begin
      upd_en   = updD && !stallD;
      btb_wr   = upd_en && ((typeD != BR_COND) || takenD);
      ctr_wr   = upd_en && (typeD == BR_COND);
      valid_d  = valid_q;
      ctr_d    = ctr_q;
      tag_d    = tag_q;
      type_d   = type_q;
      target_d = target_q;
      if (btb_wr) begin
         valid_d[upd_idx]  = 1'b1;
         tag_d[upd_idx]    = upd_tag;
         type_d[upd_idx]   = typeD;
         target_d[upd_idx] = targetD;
      end
      if (ctr_wr) begin
         if (takenD && (ctr_q[upd_idx] != CTR_MAX))
            ctr_d[upd_idx] = ctr_q[upd_idx] + 1'b1;
         else if (!takenD && (ctr_q[upd_idx] != '0))
            ctr_d[upd_idx] = ctr_q[upd_idx] - 1'b1;
      end
   end

   // ras_ptr_q addresses the top entry; a push onto a full stack lands on the oldest slot.
   always_comb begin
      ras_push    = upd_en && callD;
      ras_pop     = upd_en && (typeD == BR_RET) && (ras_cnt_q != '0);
      ras_ptr_inc = ras_ptr_q + 1'b1;
      ras_ptr_dec = ras_ptr_q - 1'b1;
      ras_d       = ras_q;
      ras_ptr_d   = ras_ptr_q;
      ras_cnt_d   = ras_cnt_q;
      if (ras_push && ras_pop) begin
         ras_d[ras_ptr_q] = pcplus4D;
      end else if (ras_push) begin
         ras_ptr_d          = ras_ptr_inc;
         ras_d[ras_ptr_inc] = pcplus4D;
         if (ras_cnt_q != RAS_FULL)
            ras_cnt_d = ras_cnt_q + 1'b1;
      end else if (ras_pop) begin
         ras_ptr_d = ras_ptr_dec;
         ras_cnt_d = ras_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= '0;
         ctr_q     <= '{default: CTR_INIT};
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         valid_q   <= valid_d;
         ctr_q     <= ctr_d;
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end

   // Payload storage is qualified by valid_q and the RAS count, so it carries no reset.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      type_q   <= type_d;
      target_q <= target_d;
      ras_q    <= ras_d;
   end

endmodule
